// File: rtl/exposure_timer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// exposure_timer
//
// Timing responder for the camera exposure controller. It holds the
// user-adjustable exposure setting and, when the controller asks for a
// start, times the exposure window and then a fixed readout window. The
// end of each window is reported to the controller, which uses those
// indications to step its own state machine.
//
// Ports:
//   Clk          - system clock, rising edge active
//   Reset        - asynchronous, active-high reset
//   Timer_start  - start request from the exposure controller (level sampled,
//                  only acted on while idle)
//   Exp_increase - synchronised button: rising edge raises the setting
//   Exp_decrease - synchronised button: rising edge lowers the setting
//   Ovf5         - exposure-complete indication
//   Ovf4         - readout-complete indication
//   Busy         - high whenever an exposure or readout is in progress
//   Exp_time     - current exposure setting in units, unsigned
//
// Parameters:
//   EXP_MIN / EXP_MAX - saturation limits of the setting (EXP_MIN >= 1,
//                       EXP_MAX <= 31 so it fits Exp_time)
//   EXP_DEFAULT       - setting after reset, EXP_MIN <= EXP_DEFAULT <= EXP_MAX
//   TICK_DIV          - clock cycles per exposure unit, >= 1
//   READ_CYCLES       - length of the readout window in cycles, >= 1
//
// Build option:
//   EXPOSURE_TIMER_STICKY_OVF_EN - when defined, Ovf5/Ovf4 are sticky flags
//   that are set by their events and cleared together when a new start is
//   accepted (or by Reset). When undefined they are single-cycle pulses.
// ---------------------------------------------------------------------------
module exposure_timer #(
   parameter int unsigned EXP_MIN     = 2,
   parameter int unsigned EXP_MAX     = 30,
   parameter int unsigned EXP_DEFAULT = 2,
   parameter int unsigned TICK_DIV    = 4,
   parameter int unsigned READ_CYCLES = 8
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Timer_start,
   input  logic       Exp_increase,
   input  logic       Exp_decrease,
   output logic       Ovf5,
   output logic       Ovf4,
   output logic       Busy,
   output logic [4:0] Exp_time
);

   // The counter must hold the largest load value of either window. The
   // width is clog2 of the largest window length, which is enough because
   // the load value is always one less than the window length.
   localparam int unsigned EXP_PROD = EXP_MAX * TICK_DIV;
   localparam int unsigned CNT_MAXV = (EXP_PROD > READ_CYCLES) ? EXP_PROD : READ_CYCLES;
   localparam int unsigned CNT_W    = (CNT_MAXV > 1) ? $clog2(CNT_MAXV) : 1;

   localparam logic [4:0]       EXP_MIN_V     = 5'(EXP_MIN);
   localparam logic [4:0]       EXP_MAX_V     = 5'(EXP_MAX);
   localparam logic [4:0]       EXP_DEFAULT_V = 5'(EXP_DEFAULT);
   localparam logic [CNT_W-1:0] READ_LOAD     = CNT_W'(READ_CYCLES - 1);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_EXPOSE  = 2'd1;
   localparam logic [1:0] ST_READOUT = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [4:0]       exp_q, exp_d;
   logic             inc_prev_q, inc_prev_d;
   logic             dec_prev_q, dec_prev_d;
   logic             ovf5_q, ovf5_d;
   logic             ovf4_q, ovf4_d;
   logic             busy_q, busy_d;

   logic             inc_rise;
   logic             dec_rise;
   logic [31:0]      prod_full;
   logic [CNT_W-1:0] exp_load;

   // Rising-edge detection on the already-synchronised buttons. The
   // previous-value registers track the inputs in every state, so a button
   // pressed during a busy window leaves no pending edge behind when the
   // timer returns to idle.
   always_comb begin
      inc_prev_d = Exp_increase;
      dec_prev_d = Exp_decrease;
      inc_rise   = Exp_increase & ~inc_prev_q;
      dec_rise   = Exp_decrease & ~dec_prev_q;
   end

   // Exposure setting: single steps that saturate at the limits. Opposing
   // edges in the same cycle cancel, and edges outside idle are dropped so
   // an exposure in progress never sees its setting move.
   always_comb begin
      exp_d = exp_q;
      if (state_q == ST_IDLE) begin
         if (inc_rise && !dec_rise) begin
            if (exp_q < EXP_MAX_V) begin
               exp_d = exp_q + 5'd1;
            end
         end else if (dec_rise && !inc_rise) begin
            if (exp_q > EXP_MIN_V) begin
               exp_d = exp_q - 5'd1;
            end
         end
      end
   end

   // Exposure window length in cycles minus one. The multiply is done at
   // 32 bits so nothing is lost, then narrowed to the counter width, which
   // is guaranteed to hold the result.
   always_comb begin
      prod_full = 32'(exp_q) * 32'(TICK_DIV);
      exp_load  = CNT_W'(prod_full - 32'd1);
   end

   // Main sequencer. Each window counts its load value down to zero and the
   // transition happens on the edge where zero is observed, so a window of
   // L cycles ends exactly L edges after it was loaded. Busy is registered
   // alongside the state so it rises on the start edge and falls on the
   // readout-complete edge.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
`ifdef EXPOSURE_TIMER_STICKY_OVF_EN
      ovf5_d  = ovf5_q;
      ovf4_d  = ovf4_q;
`else
      ovf5_d  = 1'b0;
      ovf4_d  = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (Timer_start) begin
               cnt_d   = exp_load;
               state_d = ST_EXPOSE;
               busy_d  = 1'b1;
`ifdef EXPOSURE_TIMER_STICKY_OVF_EN
               ovf5_d  = 1'b0;
               ovf4_d  = 1'b0;
`endif
            end
         end
         ST_EXPOSE: begin
            if (cnt_q == '0) begin
               ovf5_d  = 1'b1;
               cnt_d   = READ_LOAD;
               state_d = ST_READOUT;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_READOUT: begin
            if (cnt_q == '0) begin
               ovf4_d  = 1'b1;
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
            ovf5_d  = 1'b0;
            ovf4_d  = 1'b0;
         end
      endcase
   end

   // State registers. Reset aborts any window immediately and clears the
   // indications, so an interrupted exposure never reports completion.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         exp_q      <= EXP_DEFAULT_V;
         inc_prev_q <= 1'b0;
         dec_prev_q <= 1'b0;
         ovf5_q     <= 1'b0;
         ovf4_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         exp_q      <= exp_d;
         inc_prev_q <= inc_prev_d;
         dec_prev_q <= dec_prev_d;
         ovf5_q     <= ovf5_d;
         ovf4_q     <= ovf4_d;
         busy_q     <= busy_d;
      end
   end

   // All outputs come straight from flops.
   always_comb begin
      Ovf5     = ovf5_q;
      Ovf4     = ovf4_q;
      Busy     = busy_q;
      Exp_time = exp_q;
   end

endmodule

// File: tb/tb_exposure_timer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_exposure_timer
//
// Drives exposure_timer with directed and random stimulus. Every driven
// cycle updates a small behavioural model (setting value, busy window, and
// the edge numbers at which Ovf5/Ovf4 must rise) and pushes the expected
// completion events into a queue. A separate monitor samples the outputs on
// the falling edge, pops an event each time an indication rises and checks
// its kind and edge number, and checks Busy against the modelled window.
// ---------------------------------------------------------------------------
module tb_exposure_timer;

   localparam int EXP_MIN     = 2;
   localparam int EXP_MAX     = 30;
   localparam int EXP_DEFAULT = 2;
   localparam int TICK_DIV    = 4;
   localparam int READ_CYCLES = 8;

   logic       Clk          = 1'b0;
   logic       Reset        = 1'b1;
   logic       Timer_start  = 1'b0;
   logic       Exp_increase = 1'b0;
   logic       Exp_decrease = 1'b0;
   logic       Ovf5;
   logic       Ovf4;
   logic       Busy;
   logic [4:0] Exp_time;

   exposure_timer #(
      .EXP_MIN     (EXP_MIN),
      .EXP_MAX     (EXP_MAX),
      .EXP_DEFAULT (EXP_DEFAULT),
      .TICK_DIV    (TICK_DIV),
      .READ_CYCLES (READ_CYCLES)
   ) dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .Timer_start  (Timer_start),
      .Exp_increase (Exp_increase),
      .Exp_decrease (Exp_decrease),
      .Ovf5         (Ovf5),
      .Ovf4         (Ovf4),
      .Busy         (Busy),
      .Exp_time     (Exp_time)
   );

   // 10 ns clock.
   always #5 Clk = ~Clk;

   // Edge counter: after rising edge k it holds k.
   int cycleNo = 0;
   always @(posedge Clk) cycleNo <= cycleNo + 1;

   typedef struct {
      bit isOvf4;
      int edgeNo;
   } event_t;

   event_t expQ[$];

   int checks = 0;
   int errors = 0;

   // Behavioural model state.
   int modelExp      = EXP_DEFAULT;
   int busyStart     = 0;
   int busyEnd       = -1;
   int lastPressEdge = -10;
   bit incPrev       = 1'b0;
   bit decPrev       = 1'b0;

   // Monitor history.
   bit prevOvf5 = 1'b0;
   bit prevOvf4 = 1'b0;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, cycleNo);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   // Drive one cycle of inputs and advance the model for the edge that
   // will sample them. The timer is idle at edge k unless k lies after the
   // start edge of the current job and no later than its readout-complete
   // edge; a start sampled while idle opens a job of setting*TICK_DIV
   // exposure cycles followed by READ_CYCLES readout cycles.
   task automatic applyStimulus(input bit start, input bit inc, input bit dec);
      int     k;
      int     n;
      bit     idle;
      bit     incRise;
      bit     decRise;
      event_t ev;
      Timer_start  = start;
      Exp_increase = inc;
      Exp_decrease = dec;
      k       = cycleNo + 1;
      idle    = (k > busyEnd);
      incRise = inc && !incPrev;
      decRise = dec && !decPrev;
      incPrev = inc;
      decPrev = dec;
      if (incRise || decRise) lastPressEdge = k;
      if (idle && start) begin
         n         = modelExp * TICK_DIV;
         busyStart = k;
         busyEnd   = k + n + READ_CYCLES;
         ev.isOvf4 = 1'b0;
         ev.edgeNo = k + n;
         expQ.push_back(ev);
         ev.isOvf4 = 1'b1;
         ev.edgeNo = k + n + READ_CYCLES;
         expQ.push_back(ev);
      end
      if (idle && incRise && !decRise && modelExp < EXP_MAX) modelExp = modelExp + 1;
      if (idle && decRise && !incRise && modelExp > EXP_MIN) modelExp = modelExp - 1;
      step();
      if (cycleNo - lastPressEdge >= 2) checkOutput("exp_time", int'(Exp_time), modelExp);
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0);
   endtask

   task automatic press(input bit inc, input bit dec);
      applyStimulus(1'b0, inc, dec);
      applyStimulus(1'b0, 1'b0, 1'b0);
   endtask

   // Assert reset between edges; every output must drop at once, without
   // waiting for a clock edge.
   task automatic doReset();
      Timer_start  = 1'b0;
      Exp_increase = 1'b0;
      Exp_decrease = 1'b0;
      Reset        = 1'b1;
      expQ.delete();
      busyStart     = 0;
      busyEnd       = -1;
      modelExp      = EXP_DEFAULT;
      incPrev       = 1'b0;
      decPrev       = 1'b0;
      lastPressEdge = -10;
      #1;
      checkOutput("reset_ovf5", int'(Ovf5), 0);
      checkOutput("reset_ovf4", int'(Ovf4), 0);
      checkOutput("reset_busy", int'(Busy), 0);
      checkOutput("reset_exp_time", int'(Exp_time), EXP_DEFAULT);
      step();
      step();
      Reset = 1'b0;
   endtask

   task automatic matchEvent(input bit isOvf4);
      event_t ev;
      string  nm;
      nm = isOvf4 ? "ovf4_edge" : "ovf5_edge";
      if (expQ.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s: unexpected rise at edge %0d, expected none", nm, cycleNo);
      end else begin
         ev = expQ.pop_front();
         checkOutput({nm, "_kind"}, int'(isOvf4), int'(ev.isOvf4));
         checkOutput(nm, cycleNo, ev.edgeNo);
      end
   endtask

   // Monitor: every falling edge, retire overdue events, match rising
   // indications against the queue and check Busy.
   initial begin
      forever begin
         @(negedge Clk);
         while (expQ.size() > 0 && expQ[0].edgeNo < cycleNo) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: no rise by edge %0d, expected at edge %0d",
                     expQ[0].isOvf4 ? "ovf4_edge" : "ovf5_edge", cycleNo, expQ[0].edgeNo);
            void'(expQ.pop_front());
         end
         if (Ovf5 && !prevOvf5) matchEvent(1'b0);
         if (Ovf4 && !prevOvf4) matchEvent(1'b1);
`ifndef EXPOSURE_TIMER_STICKY_OVF_EN
         checkOutput("ovf5_pulse_width", int'(Ovf5 && prevOvf5), 0);
         checkOutput("ovf4_pulse_width", int'(Ovf4 && prevOvf4), 0);
         checkOutput("ovf_both_high", int'(Ovf5 && Ovf4), 0);
`endif
         checkOutput("busy", int'(Busy), int'(cycleNo >= busyStart && cycleNo < busyEnd));
         prevOvf5 = Ovf5;
         prevOvf4 = Ovf4;
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int r;
      int n;
      // Reset and idle with default setting.
      repeat (3) step();
      Reset = 1'b0;
      checkOutput("post_reset_exp_time", int'(Exp_time), EXP_DEFAULT);
      checkOutput("post_reset_busy", int'(Busy), 0);
      idleCycles(20);

      // Single start with setting 2: Ovf5 at E0+8, Ovf4 at E0+16.
      applyStimulus(1'b1, 1'b0, 1'b0);
      idleCycles(20);

      // Saturation at both ends, then cancelling edges.
      for (int i = 0; i < 40; i++) press(1'b1, 1'b0);
      idleCycles(2);
      checkOutput("exp_sat_max", int'(Exp_time), EXP_MAX);
      for (int i = 0; i < 40; i++) press(1'b0, 1'b1);
      idleCycles(2);
      checkOutput("exp_sat_min", int'(Exp_time), EXP_MIN);
      for (int i = 0; i < 3; i++) press(1'b1, 1'b0);
      press(1'b1, 1'b1);
      idleCycles(2);
      checkOutput("exp_simultaneous", int'(Exp_time), 5);

      // Button edge during an exposure of 5 units is discarded.
      applyStimulus(1'b1, 1'b0, 1'b0);
      idleCycles(3);
      press(1'b1, 1'b0);
      idleCycles(40);
      checkOutput("exp_locked_during_run", int'(Exp_time), 5);

      // Reset in the middle of an exposure.
      applyStimulus(1'b1, 1'b0, 1'b0);
      idleCycles(4);
      doReset();
      idleCycles(40);
      checkOutput("exp_after_abort", int'(Exp_time), EXP_DEFAULT);

      // Back-to-back operation with start held high.
      for (int i = 0; i < 60; i++) applyStimulus(1'b1, 1'b0, 1'b0);
      idleCycles(30);

      // Random mix of presses, starts, holds, idles and occasional resets.
      for (int it = 0; it < 300; it++) begin
         r = int'($urandom_range(0, 19));
         if (r < 6) begin
            press(1'b1, 1'b0);
         end else if (r < 10) begin
            press(1'b0, 1'b1);
         end else if (r < 11) begin
            press(1'b1, 1'b1);
         end else if (r < 14) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
         end else if (r < 16) begin
            n = int'($urandom_range(1, 40));
            for (int j = 0; j < n; j++) applyStimulus(1'b1, 1'b0, 1'b0);
         end else if (r < 19) begin
            idleCycles(int'($urandom_range(1, 30)));
         end else if ($urandom_range(0, 3) == 0) begin
            doReset();
         end else begin
            applyStimulus(1'b0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
         end
      end

      // Drain: the longest job is EXP_MAX*TICK_DIV+READ_CYCLES cycles.
      idleCycles(EXP_MAX * TICK_DIV + READ_CYCLES + 10);
      checkOutput("events_outstanding", expQ.size(), 0);
      checkOutput("final_busy", int'(Busy), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
